rotary_reg_ctrl: RTL



---
 rtl/rotary_pkg.sv | 25 ++
 rtl/rotary_reg_ctrl_sat_step.sv | 34 +++
 rtl/rotary_reg_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary register controller.
// Holds the controller FSM state encoding, the direction constants and a
// selector-width helper so every file agrees on how a register index is sized.
// No ports: this is a package.
package rotary_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   // Number of bits needed to index a bank of num_regs registers.
   function automatic int sel_width(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   localparam int DEFAULT_NUM_REGS = 4;
   localparam int SEL_W            = sel_width(DEFAULT_NUM_REGS);
   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rotary_reg_ctrl_sat_step.sv
// sat_step: combinational saturating add/subtract of a WIDTH-bit value.
// Ports:
//   cur  in  WIDTH : current register value
//   step in  WIDTH : amount to add or subtract
//   inc  in  1     : 1 = add, 0 = subtract
//   nxt  out WIDTH : result, clamped to [0, 2^WIDTH-1]
//   diff out 1     : result differs from cur (edit was not a saturated no-op)
module sat_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] step,
   input  logic             inc,
   output logic [WIDTH-1:0] nxt,
   output logic             diff
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;

   // One extra bit exposes carry-out on add and borrow on subtract,
   // which is exactly when the result must clamp instead of wrapping.
   always_comb begin
      sum = {1'b0, cur} + {1'b0, step};
      dif = {1'b0, cur} - {1'b0, step};
      if (inc) begin
         nxt = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end else begin
         nxt = dif[WIDTH] ? {WIDTH{1'b0}} : dif[WIDTH-1:0];
      end
      diff = (nxt != cur);
   end

endmodule

// File: rtl/rotary_reg_ctrl.sv
// rotary_reg_ctrl: turns rotary decoder pulses into saturating edits of a
// small register bank, with speed acceleration, sticky change flags and a
// one-cycle-latency read port for the I2C slave.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rotateEvent, direction: one detent pulse and its direction (1 = up)
//   sel_next              : pulse advancing the edited register
//   lock                  : level, discards rotate events while high
//   sel, value            : edited register index and its contents
//   rd_req, rd_addr       : read strobe and address
//   rd_data, rd_valid     : read data and its one-cycle valid pulse
//   changed               : sticky per-register modified flags
module rotary_reg_ctrl
   import rotary_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int NUM_REGS   = 4,
   parameter int ACCEL_WIN  = 1000,
   parameter int ACCEL_STEP = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rotateEvent,
   input  logic                          direction,
   input  logic                          sel_next,
   input  logic                          lock,
   output logic [sel_width(NUM_REGS)-1:0] sel,
   output logic [WIDTH-1:0]              value,
   input  logic                          rd_req,
   input  logic [sel_width(NUM_REGS)-1:0] rd_addr,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          rd_valid,
   output logic [NUM_REGS-1:0]           changed
);

   localparam int SW = sel_width(NUM_REGS);
   localparam int GW = $clog2(ACCEL_WIN + 1);
   localparam logic [GW-1:0]    GAP_MAX   = GW'(ACCEL_WIN);
   localparam logic [WIDTH-1:0] STEP_FAST = WIDTH'(ACCEL_STEP);
   localparam logic [WIDTH-1:0] STEP_SLOW = WIDTH'(1);

   state_t               state, state_nxt;
   logic                 accept;
   logic [GW-1:0]        gap;
   logic                 cap_dir;
   logic [SW-1:0]        cap_sel;
   logic [WIDTH-1:0]     cap_step;
   logic [WIDTH-1:0]     regs [NUM_REGS];
   logic [WIDTH-1:0]     new_val;
   logic                 new_diff;
   logic [NUM_REGS-1:0]  changed_nxt;

   // Next-state logic. Events are only taken in IDLE; anything arriving
   // during APPLY or SETTLE is dropped since the decoder cannot be that fast.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (rotateEvent && !lock) begin
               accept    = 1'b1;
               state_nxt = APPLY;
            end
         end
         APPLY:   state_nxt = SETTLE;
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the edit parameters at acceptance so later sel_next pulses do
   // not redirect an update in flight. The gap counter starts saturated so
   // the first event after reset is always a slow (step 1) edit.
   always_ff @(posedge clk) begin
      if (reset) begin
         gap      <= GAP_MAX;
         cap_dir  <= DIR_DEC;
         cap_sel  <= '0;
         cap_step <= STEP_SLOW;
      end else if (accept) begin
         gap      <= '0;
         cap_dir  <= direction;
         cap_sel  <= sel;
         cap_step <= (gap < GAP_MAX) ? STEP_FAST : STEP_SLOW;
      end else if (gap != GAP_MAX) begin
         gap <= gap + 1'b1;
      end
   end

   // Selection wraps naturally because NUM_REGS is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel <= '0;
      end else if (sel_next) begin
         sel <= sel + 1'b1;
      end
   end

   sat_step #(.WIDTH(WIDTH)) u_sat_step (
      .cur  (regs[cap_sel]),
      .step (cap_step),
      .inc  (cap_dir == DIR_INC),
      .nxt  (new_val),
      .diff (new_diff)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (state == APPLY) begin
         regs[cap_sel] <= new_val;
      end
   end

   // A read clears its flag, but a real edit landing in the same cycle
   // sets it again, so a change is never lost to a racing read.
   always_comb begin
      changed_nxt = changed;
      if (rd_req) begin
         changed_nxt[rd_addr] = 1'b0;
      end
      if ((state == APPLY) && new_diff) begin
         changed_nxt[cap_sel] = 1'b1;
      end
   end

   // Read data is taken from the bank before this edge's write, so a read
   // colliding with APPLY returns the pre-update value.
   always_ff @(posedge clk) begin
      if (reset) begin
         changed  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         changed  <= changed_nxt;
         rd_valid <= rd_req;
         if (rd_req) begin
            rd_data <= regs[rd_addr];
         end
      end
   end

   assign value = regs[sel];

endmodule
